// File: rtl/mm_iddmm_seq_if.sv
// Core-side port of the Montgomery task sequencer: operand load beats, task handshake and result.
interface mm_iddmm_seq_if #(
  parameter int K  = 128,
  parameter int N  = 32,
  parameter int AW = 2
);
  logic          wr_ena;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_x;
  logic [N-1:0]  wr_y;
  logic [N-1:0]  wr_m;
  logic [N-1:0]  wr_m1;
  logic          task_req;
  logic          task_end;
  logic          res_val;
  logic [K-1:0]  res;

  modport master (
    output wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req,
    input  task_end, res_val, res
  );

  modport slave (
    input  wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req,
    output task_end, res_val, res
  );
endinterface

// File: rtl/mm_iddmm_seq.sv
// Loads operands into an mm_iddmm_sp core, issues tasks at a fixed interval and
// checks each result against an expected value with saturating pass/fail/timeout counts.
module mm_iddmm_seq #(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int AW      = ((K / N) > 1) ? $clog2(K / N) : 1,
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 65535,
  parameter int CW      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CW-1:0]         rounds,
  input  logic [K-1:0]          op_x,
  input  logic [K-1:0]          op_y,
  input  logic [K-1:0]          op_m,
  input  logic [N-1:0]          op_m1,
  input  logic [K-1:0]          op_exp,
  mm_iddmm_seq_if.master        core,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         pass_cnt,
  output logic [CW-1:0]         fail_cnt,
  output logic [CW-1:0]         tmo_cnt,
  output logic [K-1:0]          last_res,
  output logic [7:0]            led
);

  localparam int W  = K / N;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(PERIOD + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(W - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(PERIOD - 1);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, CHECK, GAP} state_t;

  state_t        state;
  logic [K-1:0]  x_l, y_l, m_l, exp_l, cap;
  logic [N-1:0]  m1_l;
  logic [CW-1:0] rounds_l, task_cnt;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic          stop_l, got;

  function automatic logic [N-1:0] word_of(input logic [K-1:0] v, input int i);
    return v[i*N +: N];
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  assign led = {busy, |fail_cnt, |tmo_cnt, last_res[4:0]};

  // Operand snapshot and result capture carry no reset; they are qualified by state.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      x_l   <= op_x;
      y_l   <= op_y;
      m_l   <= op_m;
      m1_l  <= op_m1;
      exp_l <= op_exp;
    end
    if (state == REQ && core.res_val) cap <= core.res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      core.wr_ena   <= 1'b0;
      core.wr_addr  <= '0;
      core.wr_x     <= '0;
      core.wr_y     <= '0;
      core.wr_m     <= '0;
      core.wr_m1    <= '0;
      core.task_req <= 1'b0;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      tmo_cnt       <= '0;
      last_res      <= '0;
      rounds_l      <= '0;
      task_cnt      <= '0;
      tcnt          <= '0;
      gcnt          <= '0;
      stop_l        <= 1'b0;
      got           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && stop) stop_l <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            rounds_l     <= rounds;
            stop_l       <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            tmo_cnt      <= '0;
            last_res     <= '0;
            task_cnt     <= '0;
            busy         <= 1'b1;
            core.wr_ena  <= 1'b1;
            core.wr_addr <= '0;
            core.wr_x    <= word_of(op_x, 0);
            core.wr_y    <= word_of(op_y, 0);
            core.wr_m    <= word_of(op_m, 0);
            core.wr_m1   <= op_m1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (core.wr_addr == LAST_ADDR) begin
            core.wr_ena   <= 1'b0;
            core.wr_addr  <= '0;
            core.wr_x     <= '0;
            core.wr_y     <= '0;
            core.wr_m     <= '0;
            core.wr_m1    <= '0;
            core.task_req <= 1'b1;
            tcnt          <= '0;
            got           <= 1'b0;
            state         <= REQ;
          end else begin
            core.wr_addr <= core.wr_addr + AW'(1);
            core.wr_x    <= word_of(x_l, int'(core.wr_addr) + 1);
            core.wr_y    <= word_of(y_l, int'(core.wr_addr) + 1);
            core.wr_m    <= word_of(m_l, int'(core.wr_addr) + 1);
          end
        end
        REQ: begin
          if (core.res_val) got <= 1'b1;
          // task_end takes priority over an expiring timeout
          if (core.task_end) begin
            core.task_req <= 1'b0;
            state         <= CHECK;
          end else if (tcnt == TMO_LAST) begin
            core.task_req <= 1'b0;
            tmo_cnt       <= sat_inc(tmo_cnt);
            gcnt          <= '0;
            state         <= GAP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        CHECK: begin
          if (got && cap == exp_l) pass_cnt <= sat_inc(pass_cnt);
          else                     fail_cnt <= sat_inc(fail_cnt);
          last_res <= cap;
          gcnt     <= '0;
          state    <= GAP;
        end
        GAP: begin
          if (gcnt == GAP_LAST) begin
            task_cnt <= task_cnt + CW'(1);
            if ((rounds_l != '0 && task_cnt + CW'(1) == rounds_l) || stop_l || stop) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              // operands are reloaded every task since the core may overwrite its RAM
              core.wr_ena  <= 1'b1;
              core.wr_addr <= '0;
              core.wr_x    <= word_of(x_l, 0);
              core.wr_y    <= word_of(y_l, 0);
              core.wr_m    <= word_of(m_l, 0);
              core.wr_m1   <= m1_l;
              state        <= LOAD;
            end
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_iddmm_seq.sv
// Randomized bench for mm_iddmm_seq: a behavioural core model answers tasks in several modes
// and run outcomes are compared with counts derived from the task rules.
`timescale 1ns/1ps
module tb_mm_iddmm_seq;
  localparam int K = 128, N = 32, W = K / N, AW = 2;
  localparam int PERIOD = 4, TIMEOUT = 20, CW = 16, CWS = 2;
  localparam int M_PASS = 0, M_BAD = 1, M_TMO = 2, M_NORES = 3, M_SAME = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, stop, start_s, stop_s;
  logic [CW-1:0] rounds;
  logic [CWS-1:0] rounds_s;
  logic [K-1:0]  op_x, op_y, op_m, op_exp;
  logic [N-1:0]  op_m1;
  logic          busy, done, busy_s, done_s;
  logic [CW-1:0] pass_cnt, fail_cnt, tmo_cnt;
  logic [CWS-1:0] pass_s, fail_s, tmo_s;
  logic [K-1:0]  last_res, last_res_s;
  logic [7:0]    led, led_s;

  mm_iddmm_seq_if #(.K(K), .N(N), .AW(AW)) cif ();
  mm_iddmm_seq_if #(.K(K), .N(N), .AW(AW)) sif ();

  mm_iddmm_seq #(.K(K), .N(N), .AW(AW), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .reset(rst), .start(start), .stop(stop), .rounds(rounds),
    .op_x(op_x), .op_y(op_y), .op_m(op_m), .op_m1(op_m1), .op_exp(op_exp),
    .core(cif), .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .tmo_cnt(tmo_cnt), .last_res(last_res), .led(led)
  );

  mm_iddmm_seq #(.K(K), .N(N), .AW(AW), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .CW(CWS)) dut_sat (
    .clk(clk), .reset(rst), .start(start_s), .stop(stop_s), .rounds(rounds_s),
    .op_x(op_x), .op_y(op_y), .op_m(op_m), .op_m1(op_m1), .op_exp(op_exp),
    .core(sif), .busy(busy_s), .done(done_s), .pass_cnt(pass_s), .fail_cnt(fail_s),
    .tmo_cnt(tmo_s), .last_res(last_res_s), .led(led_s)
  );

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Operands the current run is supposed to be using
  logic [K-1:0] cur_x, cur_y, cur_m, cur_exp;
  logic [N-1:0] cur_m1;
  int mode = M_PASS;

  // Core model state for the main instance
  int  req_cyc, task_num, beat, gap_cnt;
  bit  gap_on, end_prev, req_prev;

  always @(negedge clk) begin
    if (rst) begin
      req_cyc = 0; task_num = 0; beat = 0; gap_cnt = 0;
      gap_on = 0; end_prev = 0; req_prev = 0;
      cif.task_end = 1'b0; cif.res_val = 1'b0; cif.res = '0;
    end else begin
      end_prev = cif.task_end;
      if (gap_on) gap_cnt++;
      if (end_prev) begin
        check("req_drop_after_end", cif.task_req, 1'b0);
        gap_on = 1; gap_cnt = 0;
      end
      if (cif.wr_ena) begin
        if (gap_on) begin
          check("gap_len", gap_cnt, PERIOD + 1);
          gap_on = 0;
        end
        check("load_beat", {cif.wr_addr, cif.wr_x, cif.wr_y, cif.wr_m, cif.wr_m1},
              {AW'(beat), cur_x[beat*N +: N], cur_y[beat*N +: N], cur_m[beat*N +: N], cur_m1});
        beat++;
      end else begin
        beat = 0;
      end
      if (done) gap_on = 0;
      if (cif.task_req) begin
        if (!req_prev) task_num++;
        req_cyc++;
      end else begin
        if (req_prev && mode == M_TMO) check("req_len_tmo", req_cyc, TIMEOUT);
        req_cyc = 0;
      end
      req_prev = cif.task_req;
      cif.task_end = 1'b0;
      cif.res_val  = 1'b0;
      if (cif.task_req) begin
        case (mode)
          M_PASS, M_BAD: begin
            if (req_cyc == 9) begin
              cif.res_val = 1'b1;
              cif.res = (mode == M_PASS) ? cur_exp : cur_exp ^ K'(1);
            end
            if (req_cyc == 10) cif.task_end = 1'b1;
          end
          M_NORES: if (req_cyc == 10) cif.task_end = 1'b1;
          M_SAME: begin
            // an earlier wrong value must be superseded by the one arriving with task_end
            if (req_cyc == 9) begin cif.res_val = 1'b1; cif.res = cur_exp ^ K'(2); end
            if (req_cyc == 10) begin cif.res_val = 1'b1; cif.res = cur_exp; cif.task_end = 1'b1; end
          end
          default: ;
        endcase
      end
    end
  end

  // Core model for the narrow-counter instance: always answers with a wrong result
  int s_cyc, s_task;
  bit s_prev;
  always @(negedge clk) begin
    if (rst) begin
      s_cyc = 0; s_task = 0; s_prev = 0;
      sif.task_end = 1'b0; sif.res_val = 1'b0; sif.res = '0;
    end else begin
      if (sif.task_req) begin
        if (!s_prev) s_task++;
        s_cyc++;
      end else begin
        s_cyc = 0;
      end
      s_prev = sif.task_req;
      sif.task_end = sif.task_req && s_cyc == 3;
      sif.res_val  = sif.task_end;
      sif.res      = cur_exp ^ K'(1);
    end
  end

  function automatic void ref_counts(input int md, input int ntasks, input int maxv,
                                     output int p, output int f, output int t);
    p = 0; f = 0; t = 0;
    for (int i = 0; i < ntasks; i++) begin
      if (md == M_PASS || md == M_SAME) p++;
      else if (md == M_TMO)             t++;
      else                              f++;
    end
    if (p > maxv) p = maxv;
    if (f > maxv) f = maxv;
    if (t > maxv) t = maxv;
  endfunction

  task automatic new_ops();
    for (int i = 0; i < W; i++) begin
      op_x[i*N +: N]   = $urandom;
      op_y[i*N +: N]   = $urandom;
      op_m[i*N +: N]   = $urandom;
      op_exp[i*N +: N] = $urandom;
    end
    op_m1 = $urandom;
    cur_x = op_x; cur_y = op_y; cur_m = op_m; cur_exp = op_exp; cur_m1 = op_m1;
  endtask

  task automatic launch(input int md, input int nr);
    mode = md;
    new_ops();
    rounds = CW'(nr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    if (seen) check({tag, "_idle_at_done"}, busy, 1'b0);
    n = 0;
    repeat (PERIOD + W + 4) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    check({tag, "_single_done"}, n, 0);
  endtask

  task automatic check_counts(input string tag, input int md, input int ntasks,
                              input logic [K-1:0] lr, input bit chk_lr);
    int p, f, t;
    ref_counts(md, ntasks, (1 << CW) - 1, p, f, t);
    check({tag, "_pass_cnt"}, pass_cnt, p);
    check({tag, "_fail_cnt"}, fail_cnt, f);
    check({tag, "_tmo_cnt"}, tmo_cnt, t);
    if (chk_lr) begin
      check({tag, "_last_res"}, last_res, lr);
      check({tag, "_led"}, led, {1'b0, f != 0, t != 0, lr[4:0]});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, base, p, f, t;
    rst = 1'b1; start = 1'b0; stop = 1'b0; rounds = '0;
    start_s = 1'b0; stop_s = 1'b0; rounds_s = '0;
    op_x = '0; op_y = '0; op_m = '0; op_exp = '0; op_m1 = '0;
    cur_x = '0; cur_y = '0; cur_m = '0; cur_exp = '0; cur_m1 = '0;
    repeat (3) @(negedge clk);

    check("rst_task_req", cif.task_req, 1'b0);
    check("rst_wr_ena", cif.wr_ena, 1'b0);
    check("rst_wr_bus", {cif.wr_addr, cif.wr_x, cif.wr_y, cif.wr_m, cif.wr_m1}, '0);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_counters", {pass_cnt, fail_cnt, tmo_cnt}, '0);
    check("rst_last_res", last_res, '0);
    check("rst_led", led, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Basic pass, with load/request timing
    launch(M_PASS, 3);
    check("t1_busy", busy, 1'b1);
    check("t1_load_k1", {cif.wr_ena, cif.task_req}, 2'b10);
    for (int k = 2; k <= W; k++) begin
      @(negedge clk);
      check("t1_load_win", {cif.wr_ena, cif.task_req}, 2'b10);
    end
    @(negedge clk);
    check("t1_first_req", {cif.wr_ena, cif.task_req}, 2'b01);
    wait_done("basic", 400);
    check_counts("basic", M_PASS, 3, cur_exp, 1'b1);

    // Mismatch, with a start pulse while busy that must be ignored
    launch(M_BAD, 3);
    n = 0;
    while (fail_cnt != 1 && n < 200) begin @(negedge clk); n++; end
    check("t2_first_fail_seen", fail_cnt, 1);
    op_x = ~op_x; op_exp = ~op_exp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mismatch", 400);
    check_counts("mismatch", M_BAD, 3, cur_exp ^ K'(1), 1'b1);
    check("mismatch_led6", led[6], 1'b1);

    // Timeout
    launch(M_TMO, 2);
    wait_done("timeout", 400);
    check_counts("timeout", M_TMO, 2, '0, 1'b1);

    // Continuous mode ended by stop during the fifth task
    base = task_num;
    launch(M_PASS, 0);
    n = 0;
    while (!(task_num == base + 5 && req_cyc >= 3) && n < 600) begin @(negedge clk); n++; end
    check("cont_reached_task5", task_num - base, 5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("cont_stop", 400);
    check_counts("cont_stop", M_PASS, 5, cur_exp, 1'b1);

    // Task end with no result
    launch(M_NORES, 2);
    wait_done("nores", 400);
    check_counts("nores", M_NORES, 2, '0, 1'b0);

    // Result arriving in the same cycle as task_end
    launch(M_SAME, 2);
    wait_done("same_cycle", 400);
    check_counts("same_cycle", M_SAME, 2, cur_exp, 1'b1);

    // Reset while a request is outstanding
    launch(M_PASS, 3);
    n = 0;
    while (!(pass_cnt == 1 && cif.task_req) && n < 300) begin @(negedge clk); n++; end
    check("rstmid_in_req2", {pass_cnt == 1, cif.task_req}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_task_req", cif.task_req, 1'b0);
    check("rstmid_wr", {cif.wr_ena, cif.wr_addr, cif.wr_x}, '0);
    check("rstmid_busy_done", {busy, done}, 2'b00);
    check("rstmid_counters", {pass_cnt, fail_cnt, tmo_cnt}, '0);
    check("rstmid_last_res_led", {last_res, led}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Saturation on the narrow-counter instance
    new_ops();
    base = s_task;
    rounds_s = '0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    n = 0;
    while (!(s_task == base + 5 && s_cyc >= 1) && n < 600) begin @(negedge clk); n++; end
    check("sat_reached_task5", s_task - base, 5);
    stop_s = 1'b1;
    @(negedge clk);
    stop_s = 1'b0;
    n = 0;
    while (!done_s && n < 400) begin @(negedge clk); n++; end
    check("sat_done_seen", done_s, 1'b1);
    ref_counts(M_BAD, 5, (1 << CWS) - 1, p, f, t);
    check("sat_fail_cnt", fail_s, f);
    check("sat_pass_tmo", {pass_s, tmo_s}, {CWS'(p), CWS'(t)});
    check("sat_led6", led_s[6], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mm_iddmm_seq.md
# mm_iddmm_seq

Parametrised task sequencer for the `mm_iddmm_sp` Montgomery multiplier core. It loads K-bit operands into the core word by word, issues `task_req`/`task_end` handshaked tasks at a programmable interval, and captures each result. Each result is checked against an expected value, with pass/fail/timeout counts kept. It sits between the board top (or a host register block) and one `mm_iddmm_sp` instance. It replaces the fixed free-running demo trigger with a loadable, self-checking, bounded-or-continuous test driver.

## Interface
- `K`, 128, operand width in bits; must be a multiple of `N`
- `N`, 32, core word width; `W = K/N` words per operand
- `AW`, `$clog2(K/N)`, word address width (min 1)
- `PERIOD`, 1000, idle cycles between task completion and next load (≥1)
- `TIMEOUT`, 65535, max cycles `task_req` may stay high without `task_end`
- `CW`, 16, width of pass/fail/timeout counters

- `clk` in 1 — single clock
- `reset` in 1 — synchronous, active-high
- `start` in 1 — pulse; begins a run when idle
- `stop` in 1 — pulse; ends a run after the current task
- `rounds` in CW — tasks per run; 0 = continuous until `stop`
- `op_x`, `op_y`, `op_m` in K — operands; sampled at `start`
- `op_m1` in N — −m⁻¹ mod 2^N; sampled at `start`
- `op_exp` in K — expected result; sampled at `start`
- `wr_ena` out 1; `wr_addr` out AW; `wr_x`, `wr_y`, `wr_m`, `wr_m1` out N — core load port
- `task_req` out 1; `task_end` in 1 — core handshake
- `res_val` in 1; `res` in K — core result
- `busy` out 1; `done` out 1 (one-cycle pulse at run end)
- `pass_cnt`, `fail_cnt`, `tmo_cnt` out CW — saturating counters
- `last_res` out K — most recent captured result
- `led` out 8 — `{busy, |fail_cnt, |tmo_cnt, last_res[4:0]}`

## Operation
- States: IDLE, LOAD, REQ, CHECK, GAP.
- **IDLE**
  - `start` latches all `op_*` and `rounds`.
  - Clears the three counters and `last_res`.
  - Moves to LOAD.
- **LOAD** (W cycles)
  - `wr_ena=1` and `wr_addr=i` for i = 0..W−1, least-significant word first.
  - `wr_x/y/m = op[i*N +: N]`.
  - `wr_m1 = op_m1` on every beat.
  - After the last beat, goes to REQ.
- **REQ**
  - `task_req=1`, held high until `task_end` is sampled high.
  - Timeout counter starts at 0 on REQ entry.
  - If the counter reaches TIMEOUT: `tmo_cnt++`, `task_req` drops, and the state goes to GAP (the task is not counted as pass or fail).
  - The result register captures `res` on any cycle with `res_val=1` while in REQ.
- **CHECK** (1 cycle, entered on `task_end`)
  - `task_req` is already low in this cycle.
  - If a result was captured and it equals `op_exp`: `pass_cnt++`.
  - Otherwise (mismatch or no `res_val` seen): `fail_cnt++`.
  - `last_res` updates to the captured value.
- **GAP** (PERIOD cycles)
  - Increments the task count.
  - Ends the run (`done` pulse, go to IDLE) if any of these holds: `rounds≠0` and task count = `rounds`; or a `stop` pulse was latched.
  - Otherwise returns to LOAD. Operands are reloaded every task because the core may clobber its RAM.
- **`stop`**: latched in any non-IDLE state; takes effect only at the GAP exit, so no task is aborted.
- **Counters**: saturate at 2^CW−1.
- **Inputs ignored**: `start` while busy; `stop` in IDLE.
- **`busy`**: 1 in every state except IDLE.

## Timing
- **Reset values**: state IDLE; `task_req`, `wr_ena`, `busy`, `done` = 0; `wr_addr`, `wr_*` = 0; all counters, `last_res` and `led` = 0.
- **Reset mid-operation**: everything returns to reset values on the next edge, including deassertion of a high `task_req`.
- **Start to first write**: `start` at edge t gives `wr_ena` high for edges t+1 .. t+W.
- **First request**: `task_req` goes high at t+W+1.
- **Handshake end**: `task_end` sampled at edge e gives `task_req=0` from e+1, CHECK at e+1, counter update visible at e+2.
- **Same-cycle `res_val` and `task_end`**: the result is captured and used in CHECK.
- **Same-cycle `task_end` and timeout**: `task_end` wins.
- **Next load**: begins PERIOD+1 cycles after CHECK.
- **`done`**: asserted on the cycle the state returns to IDLE.

## Test plan
- **Basic pass**: K=128, N=32, rounds=3, PERIOD=4; core model returns `op_exp` 10 cycles after `task_req` → `pass_cnt=3`, `fail_cnt=0`, `tmo_cnt=0`. Each load shows `wr_addr` 0,1,2,3 with LSW first; one `done` pulse.
- **Mismatch**: model returns `op_exp^1` → `fail_cnt=3`, `last_res=op_exp^1`, `led[6]=1`.
- **Timeout**: TIMEOUT=20, model never asserts `task_end` → `task_req` high for exactly 20 cycles per task; `tmo_cnt=rounds`; no pass/fail counts.
- **Continuous and stop**: rounds=0; pulse `stop` mid-REQ of task 5 → task 5 completes and is counted, then `done`; total counted tasks = 5.
- **Missing result**: `task_end` with no `res_val` → `fail_cnt++`.
- **Edge cases**: same-cycle `res_val`/`task_end` gives a pass.
- **Reset mid-REQ**: all outputs reach reset values on the next edge.
- **Saturation**: CW=2, 5 failing tasks → `fail_cnt=3`.
